data_sram_like_slave: RTL

- Responder end of the CPU data-memory sram-like interface. Memory/ld stages issue requests; this block returns `data_ok` and `rdata`.
- Word-addressed on-chip memory with a fixed response latency and up to DEPTH outstanding transactions.
- Byte-lane write strobes are derived from size and address.
- Used as the data-side memory model behind the pipeline, and as the template for the later AXI bridge.

---
 rtl/data_sram_like_slave_pkg.sv | 36 +++
 rtl/data_sram_like_slave_if.sv | 17 +
 rtl/data_sram_like_slave_resp_fifo.sv | 74 +++++++
 rtl/data_sram_like_slave.sv | 68 ++++++
 4 files changed

// File: rtl/data_sram_like_slave_pkg.sv
// Shared types and encodings for the data-side sram-like responder.
// Holds the size codes, the request bundle width and the byte-strobe helper.
package data_sram_like_slave_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned SRAM_LIKE_REQ_WD = 1 + 2 + 32 + DATA_W;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } sram_like_req_t;

    typedef struct packed {
        logic              is_load;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } resp_entry_t;

    // Misaligned halfword/word accesses get no lanes, which suppresses the store.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_strobe = 4'b0001 << lane;
            SZ_HALF: byte_strobe = lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
            default: byte_strobe = (lane == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_like_slave_if.sv
// Data-side sram-like bus between a memory-stage requester and a memory responder.
interface data_sram_like_slave_if;
    import data_sram_like_slave_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/data_sram_like_slave_resp_fifo.sv
// In-order queue of pending responses; each entry counts down to its response cycle.
module data_sram_like_slave_resp_fifo
    import data_sram_like_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_is_load,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              head_ready,
    output logic              head_is_load,
    output logic [DATA_W-1:0] head_data
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    resp_entry_t      ent [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PtrW-1:0]  head;
    logic [PtrW-1:0]  tail;
    logic [CntW-1:0]  count;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == CntW'(DEPTH));
    assign empty        = (count == '0);
    assign head_ready   = vld[head] && (ent[head].cnt == '0);
    assign head_is_load = ent[head].is_load;
    assign head_data    = ent[head].data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            // Non-head entries keep counting so the head is always the first to expire.
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && ent[i].cnt != '0) begin
                    ent[i].cnt <= ent[i].cnt - 1'b1;
                end
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= ptr_inc(head);
            end
            if (push) begin
                vld[tail]         <= 1'b1;
                ent[tail].is_load <= push_is_load;
                ent[tail].data    <= push_data;
                ent[tail].cnt     <= CNT_W'(LAT - 1);
                tail              <= ptr_inc(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side sram-like responder: word memory accessed at acceptance, responses
// returned in order a fixed LAT cycles later.
module data_sram_like_slave
    import data_sram_like_slave_pkg::*;
#(
    parameter int unsigned AW    = 10,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_like_slave_if.slave bus
);
    logic [DATA_W-1:0] mem [2**AW];

    sram_like_req_t    rq;
    logic [AW-1:0]     word_idx;
    logic [3:0]        strb;
    logic              accept;
    logic [DATA_W-1:0] load_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_ready;
    logic              head_is_load;
    logic [DATA_W-1:0] head_data;
    logic              unused_sig;

    assign rq        = '{wr: bus.wr, size: bus.size, addr: bus.addr, wdata: bus.wdata};
    assign word_idx  = rq.addr[AW+1:2];
    assign strb      = byte_strobe(rq.size, rq.addr[1:0]);
    assign accept    = bus.req && !fifo_full;
    assign load_word = mem[word_idx];

    // Memory is deliberately left out of reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (accept && rq.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[word_idx][8*b +: 8] <= rq.wdata[8*b +: 8];
                end
            end
        end
    end

    data_sram_like_slave_resp_fifo #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) u_resp_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (accept),
        .push_is_load (!rq.wr),
        .push_data    (load_word),
        .pop          (head_ready),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head_ready   (head_ready),
        .head_is_load (head_is_load),
        .head_data    (head_data)
    );

    assign bus.addr_ok = !fifo_full;
    assign bus.data_ok = head_ready;
    assign bus.rdata   = (head_ready && head_is_load) ? head_data : '0;

    assign unused_sig = ^{rq.addr[31:AW+2], fifo_empty};

endmodule
